// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and helpers for the inter-stage pipeline buffer.
package pipe_pkg;

    localparam int OCC_WIDTH = 2;

    // Encoding equals the number of held entries, so occupancy is a direct copy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Entries discarded by a flush: the head unless it leaves this cycle, plus the skid entry.
    function automatic logic [1:0] kill_inc(input logic m_vld,
                                            input logic s_vld,
                                            input logic out_rdy);
        kill_inc = {1'b0, m_vld & ~out_rdy} + {1'b0, s_vld};
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter; an increment of up to 2 is added and the sum is clamped.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH:0]   sum;

    // Sum in one extra bit; the carry-out flags overflow since inc <= 2.
    always_comb begin
        sum     = {1'b0, value_q} + (WIDTH+1)'(inc);
        value_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        if (clr) begin
            value_d = '0;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage buffer: valid/ready handshake, flush with retained
// sideband, optional 2-entry skid so out_ready never reaches in_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 16,
    parameter int SKID       = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic [CNT_WIDTH-1:0]  killed_cnt
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic [KEEP_WIDTH-1:0] s_keep_q, s_keep_d;
    logic                  m_vld, s_vld;
    logic                  accept, in_fire, out_fire;
    logic [1:0]            kill_w;

    assign m_vld    = (state_q != EMPTY);
    assign s_vld    = (state_q == FULL);
    assign out_fire = m_vld & out_ready;
    assign in_fire  = in_valid & accept;

    // Acceptance: registered-state only with the skid, pass-through otherwise.
    always_comb begin
        if (SKID != 0) begin
            accept = (state_q != FULL) & ~flush;
        end else begin
            accept = (~m_vld | out_ready) & ~flush;
        end
    end

    // Stage is always ready while held in reset; flops accept nothing then anyway.
    assign in_ready = accept | ~reset;

    // Next-state and datapath: flush wins, otherwise move entries in arrival order.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_keep_d = m_keep_q;
        s_data_d = s_data_q;
        s_keep_d = s_keep_q;
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            m_keep_d = in_keep;
            s_data_d = '0;
            s_keep_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_data_d = in_data;
                        m_keep_d = in_keep;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_data_d = in_data;
                        m_keep_d = in_keep;
                    end else if (in_fire) begin
                        s_data_d = in_data;
                        s_keep_d = in_keep;
                        state_d  = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_data_d = s_data_q;
                        m_keep_d = s_keep_q;
                        state_d  = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            m_data_q <= '0;
            m_keep_q <= '0;
            s_data_q <= '0;
            s_keep_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_keep_q <= m_keep_d;
            s_data_q <= s_data_d;
            s_keep_q <= s_keep_d;
        end
    end

    assign kill_w = flush ? kill_inc(m_vld, s_vld, out_ready) : 2'd0;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_kill_cnt (
        .clk  (clk),
        .rst_n(reset),
        .clr  (1'b0),
        .inc  (kill_w),
        .value(killed_cnt)
    );

    assign out_valid = m_vld;
    assign out_data  = m_data_q;
    assign out_keep  = m_keep_q;
    assign occupancy = OCC_WIDTH'(state_q);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: skid instance (2-bit kill counter) with a scoreboard, plus a
// pass-through instance for the combinational ready path.
module tb_pipe_stage_buf;

    localparam int CNT_MAX = 3;

    typedef struct {
        logic [63:0] data;
        logic [15:0] keep;
    } ent_t;

    logic        clk;
    logic        reset;
    // Skid instance
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [15:0] in_keep, out_keep;
    logic [1:0]  occupancy;
    logic [1:0]  killed_cnt;
    // Pass-through instance
    logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [63:0] z_in_data, z_out_data;
    logic [15:0] z_in_keep, z_out_keep;
    logic [1:0]  z_occupancy;
    logic [7:0]  z_killed_cnt;

    ent_t sb[$];
    int   exp_killed;
    int   n_assert;
    int   n_fail;

    pipe_stage_buf #(.DATA_WIDTH(64), .KEEP_WIDTH(16), .SKID(1), .CNT_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .occupancy(occupancy), .killed_cnt(killed_cnt)
    );

    pipe_stage_buf #(.DATA_WIDTH(64), .KEEP_WIDTH(16), .SKID(0), .CNT_WIDTH(8)) dut_z (
        .clk(clk), .reset(reset), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data), .in_keep(z_in_keep),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data), .out_keep(z_out_keep),
        .occupancy(z_occupancy), .killed_cnt(z_killed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the model, return #1 after the rising edge.
    task automatic cycle();
        logic inf, outf;
        ent_t e;
        int   k;
        @(negedge clk);
        inf  = in_valid & in_ready;
        outf = out_valid & out_ready;
        chk("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        chk("occupancy", {62'd0, occupancy}, 64'(sb.size()));
        chk("killed_cnt", {62'd0, killed_cnt}, 64'(exp_killed));
        if (outf) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_keep", {48'd0, out_keep}, {48'd0, e.keep});
            end
        end
        if (flush) begin
            chk("in_ready_flush", {63'd0, in_ready}, 64'd0);
            k = sb.size();
            exp_killed = (exp_killed + k > CNT_MAX) ? CNT_MAX : exp_killed + k;
            sb.delete();
        end else if (inf) begin
            e.data = in_data;
            e.keep = in_keep;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Two entries into the skid instance with the consumer stalled.
    task automatic fill_two(input logic [63:0] a, input logic [63:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a; in_keep = a[15:0];
        cycle();
        in_data   = b; in_keep = b[15:0];
        cycle();
        in_valid  = 1'b0;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; exp_killed = 0;
        flush = 0; in_valid = 0; in_data = '0; in_keep = '0; out_ready = 0;
        z_flush = 0; z_in_valid = 0; z_in_data = '0; z_in_keep = '0; z_out_ready = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_keep", {48'd0, out_keep}, 64'd0);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_killed", {62'd0, killed_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Streaming with the consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 64'(i);
            in_keep = 16'(100 + i);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            cycle();
            chk("stream_occ", {62'd0, occupancy}, 64'd1);
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_drained", {62'd0, occupancy}, 64'd0);

        // Back-pressure fills the skid, then drains in order
        fill_two(64'hA, 64'hB);
        chk("bp_occ_full", {62'd0, occupancy}, 64'd2);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        cycle();
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        cycle();
        chk("bp_occ_empty", {62'd0, occupancy}, 64'd0);

        // Flush while FULL and stalled: both entries killed, sideband retained
        fill_two(64'hC, 64'hD);
        flush = 1'b1; in_keep = 16'h1234;
        cycle();
        flush = 1'b0;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_out_data", out_data, 64'd0);
        chk("flush_out_keep", {48'd0, out_keep}, 64'h1234);
        chk("flush_occ", {62'd0, occupancy}, 64'd0);
        chk("flush_killed2", {62'd0, killed_cnt}, 64'd2);

        // Flush while ONE with the head leaving: nothing killed, no input taken
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE; in_keep = 16'hE;
        cycle();
        in_data = 64'hF; in_keep = 16'hF; flush = 1'b1; out_ready = 1'b1;
        #1;
        chk("flush1_in_ready", {63'd0, in_ready}, 64'd0);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_killed", {62'd0, killed_cnt}, 64'd2);
        chk("flush1_empty", {63'd0, out_valid}, 64'd0);

        // Saturation of the 2-bit kill counter
        fill_two(64'h10, 64'h11);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("sat_killed3", {62'd0, killed_cnt}, 64'd3);
        fill_two(64'h12, 64'h13);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("sat_stays3", {62'd0, killed_cnt}, 64'd3);

        // Pass-through variant: ready follows out_ready in the same cycle
        z_out_ready = 1'b0; z_in_valid = 1'b1; z_in_data = 64'h55; z_in_keep = 16'h5;
        cycle();
        z_in_valid = 1'b0;
        chk("z_out_valid", {63'd0, z_out_valid}, 64'd1);
        chk("z_out_data", z_out_data, 64'h55);
        chk("z_in_ready_low", {63'd0, z_in_ready}, 64'd0);
        z_out_ready = 1'b1;
        #1;
        chk("z_in_ready_comb", {63'd0, z_in_ready}, 64'd1);
        cycle();
        chk("z_occ_empty", {62'd0, z_occupancy}, 64'd0);

        // Asynchronous reset between clock edges
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77; in_keep = 16'h9;
        cycle();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_out_keep", {48'd0, out_keep}, 64'd0);
        chk("arst_occ", {62'd0, occupancy}, 64'd0);
        chk("arst_killed", {62'd0, killed_cnt}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        exp_killed = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed ID/EX-style stage registers.
- A generic inter-stage pipeline buffer with a valid/ready handshake, flush, and an optional 2-entry skid so back-pressure never combinationally crosses the stage.
- On flush it retains a designated sideband field (e.g. saved PC), in the same way the stage registers keep their saved PC.
- Counts in-flight instructions killed by flush, which feeds branch-predictor misprediction statistics.

Parameters:
- DATA_WIDTH, 64, payload width (packed pc/operands/opcode/inst); cleared on flush.
- KEEP_WIDTH, 16, sideband width retained across flush (loaded from in_keep even on flush).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with pass-through ready.
- CNT_WIDTH, 8, width of the saturating killed-entry counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held entries this cycle.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept the entry.
- in_data  in  DATA_WIDTH  upstream payload.
- in_keep  in  KEEP_WIDTH  upstream sideband.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  DATA_WIDTH  head payload.
- out_keep  out  KEEP_WIDTH  head sideband.
- occupancy  out  2  entries held (0..2).
- killed_cnt  out  CNT_WIDTH  saturating count of entries discarded by flush.

Behaviour:
- Handshakes and definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Latency from in_fire to out_valid is 1 cycle.
- Storage:
  - Main register M drives the outputs.
  - Skid register S exists only when SKID=1.
  - State encoding: EMPTY, ONE (M valid), FULL (M and S valid).
- Reset (reset=0, asynchronous):
  - State goes to EMPTY.
  - out_valid=0, out_data=0, out_keep=0, S=0, occupancy=0, killed_cnt=0.
  - in_ready=1 while reset is low.
- in_ready:
  - SKID=1: in_ready = (state!=FULL) & !flush, a function of registered state only. There is no path from out_ready.
  - SKID=0: in_ready = (!out_valid | out_ready) & !flush.
- Transitions, SKID=1, when flush is low:
  - EMPTY, in_fire: M<=in, go to ONE.
  - ONE, in_fire & out_fire: M<=in, stay in ONE.
  - ONE, in_fire & !out_fire: S<=in, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: M<=S, go to ONE. in_fire is impossible in FULL.
  - No fire: hold.
- SKID=0: same rules with FULL unreachable.
- Order: entries leave in arrival order. No duplication, no loss except by flush.
- Flush (priority below reset, above everything else):
  - Next state is EMPTY. M and S data are cleared to 0.
  - out_keep<=in_keep regardless of in_valid.
  - The head is still presented during the flush cycle. If out_fire occurs that cycle, the transfer is completed and not counted as killed.
  - No input is accepted during flush.
  - killed_cnt += (M valid & !out_ready) + (S valid), saturating at 2^CNT_WIDTH-1. The increment may be 2, and saturation is applied to the sum.
- When draining to EMPTY without flush, out_data/out_keep hold their last value. Consumers qualify with out_valid.
- occupancy is registered and equals the number of valid entries: EMPTY=0, ONE=1, FULL=2.
- Reset asserted mid-transfer: immediate clear. No handshake completes on that edge.

Decomposition:
- Package pipe_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - OCC_WIDTH=2;
  - a function computing the kill increment.
- Sub-module sat_counter (parameter WIDTH; inputs inc[1:0] and clr; output value) implements killed_cnt. The same counter is reused by the predictor stats.

Test Plan:
1. Stream, SKID=1: reset release, in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1. Required: out_data 1,2,3,4 one cycle later, in_ready constantly 1, occupancy 1.
2. Back-pressure: out_ready=0 while feeding 0xA then 0xB. Required: occupancy reaches 2, in_ready=0 the cycle after 0xB is accepted. Then raise out_ready: outputs 0xA then 0xB, in_ready returns to 1 after the first pop.
3. Flush in FULL with out_ready=0 and in_keep=0x1234. Required next cycle: out_valid=0, out_data=0, out_keep=0x1234, occupancy=0, killed_cnt +2.
4. Flush in ONE with out_ready=1. Required: the head transfer completes, killed_cnt unchanged, state EMPTY, and in_valid=1 in the same cycle is not accepted (in_ready=0).
5. Saturation: CNT_WIDTH=2 with killed_cnt=2, then a FULL flush. Required: killed_cnt=3, and it stays 3 on further flushes.
6. SKID=0 and async reset:
   - SKID=0: out_ready=0 with an entry held gives in_ready=0; toggling out_ready=1 gives in_ready=1 in the same cycle.
   - Async reset: assert reset=0 between clock edges. Required: outputs go to 0 immediately without a clock edge.
